// File: rtl/ssio_delay_calib_if.sv
// ssio_delay_calib_if: training data in, delay-line control and lock status out
interface ssio_delay_calib_if #(
  parameter int WIDTH = 1,
  parameter int TAP_WIDTH = 5
);
  logic start;
  logic [WIDTH-1:0] sample_d;
  logic [TAP_WIDTH-1:0] delay_tap;
  logic delay_load;
  logic busy;
  logic locked;
  logic error;
  logic [TAP_WIDTH-1:0] eye_start;
  logic [TAP_WIDTH:0] eye_width;
  modport master(
    input start, sample_d,
    output delay_tap, delay_load, busy, locked, error, eye_start, eye_width
  );
  modport slave(
    output start, sample_d,
    input delay_tap, delay_load, busy, locked, error, eye_start, eye_width
  );
endinterface

// File: rtl/ssio_delay_calib.sv
// ssio_delay_calib: sweeps every delay tap against an alternating training word and loads the centre of the widest passing eye
module ssio_delay_calib #(
  parameter int WIDTH = 1,
  parameter int TAP_WIDTH = 5,
  parameter logic [WIDTH-1:0] PATTERN = '0,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_CYCLES = 64,
  parameter int MIN_EYE = 2
) (
  input logic clk,
  input logic rst,
  ssio_delay_calib_if.master io
);
  localparam int MAXC = SETTLE_CYCLES > CHECK_CYCLES ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int LW = TAP_WIDTH + 1;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, DONE} state_t;
  state_t state;
  logic [TAP_WIDTH-1:0] tap, run_start, best_start, ext_start, fin_start;
  logic [LW-1:0] run_len, best_len, ext_len, fin_len, center;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] prev;
  logic pass, last, close, better, ok;
  // Outcome of this tap's EVAL, including the forced close of a run at the last tap
  always_comb begin
    last = &tap;
    ext_len = pass ? run_len + 1'b1 : run_len;
    ext_start = (pass && run_len == '0) ? tap : run_start;
    close = !pass || last;
    better = close && ext_len > best_len;
    fin_len = better ? ext_len : best_len;
    fin_start = better ? ext_start : best_start;
    center = {1'b0, fin_start} + ((fin_len - 1'b1) >> 1);
    ok = fin_len >= LW'(MIN_EYE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tap <= '0;
      run_start <= '0;
      run_len <= '0;
      best_start <= '0;
      best_len <= '0;
      cnt <= '0;
      prev <= '0;
      pass <= 1'b0;
      io.delay_tap <= '0;
      io.delay_load <= 1'b0;
      io.busy <= 1'b0;
      io.locked <= 1'b0;
      io.error <= 1'b0;
      io.eye_start <= '0;
      io.eye_width <= '0;
    end else begin
      io.delay_load <= 1'b0;
      case (state)
        IDLE, DONE: if (io.start) begin
          state <= LOAD;
          tap <= '0;
          run_start <= '0;
          run_len <= '0;
          best_start <= '0;
          best_len <= '0;
          io.delay_tap <= '0;
          io.delay_load <= 1'b1;
          io.busy <= 1'b1;
          io.locked <= 1'b0;
          io.error <= 1'b0;
          io.eye_start <= '0;
          io.eye_width <= '0;
        end
        LOAD: begin
          state <= SETTLE;
          cnt <= '0;
        end
        SETTLE: begin
          cnt <= cnt == CW'(SETTLE_CYCLES - 1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(SETTLE_CYCLES - 1)) state <= CHECK;
        end
        CHECK: begin
          cnt <= cnt + 1'b1;
          prev <= io.sample_d;
          pass <= cnt == '0 ? (io.sample_d == PATTERN || io.sample_d == ~PATTERN)
                            : pass && io.sample_d == ~prev;
          if (cnt == CW'(CHECK_CYCLES - 1)) state <= EVAL;
        end
        EVAL: begin
          best_len <= fin_len;
          best_start <= fin_start;
          run_len <= close ? '0 : ext_len;
          run_start <= ext_start;
          io.delay_load <= 1'b1;
          if (last) begin
            state <= CENTER;
            io.delay_tap <= ok ? center[TAP_WIDTH-1:0] : '0;
            io.locked <= ok;
            io.error <= !ok;
            io.eye_start <= fin_start;
            io.eye_width <= fin_len;
          end else begin
            state <= LOAD;
            tap <= tap + 1'b1;
            io.delay_tap <= tap + 1'b1;
          end
        end
        CENTER: begin
          state <= DONE;
          io.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ssio_delay_calib.sv
// tb_ssio_delay_calib: delay-line/link model driving training data, checked against a window-search reference model
module tb_ssio_delay_calib;
  localparam int W = 4;
  localparam int TW = 5;
  localparam int NT = 32;
  localparam logic [W-1:0] PAT = 4'h5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  ssio_delay_calib_if #(.WIDTH(W), .TAP_WIDTH(TW)) bus();
  ssio_delay_calib #(.WIDTH(W), .TAP_WIDTH(TW), .PATTERN(PAT), .SETTLE_CYCLES(4),
    .CHECK_CYCLES(8), .MIN_EYE(2)) dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  logic [NT-1:0] link_mask = '0;
  int glitch_tap = -1;
  int phase_off = 0;
  logic [TW-1:0] lat_tap = '0;
  int since = 0;
  int slip = 0;
  logic [TW-1:0] loads[$];
  logic rec = 1'b0;
  logic [TW-1:0] prev_tap = '0;
  int tap_moves = 0;

  // Delay line latches the tap on delay_load; the link is clean at passing taps, noise elsewhere
  always @(posedge clk)
    if (bus.delay_load) begin
      lat_tap <= bus.delay_tap;
      since <= 0;
    end else since <= since + 1;

  always @(negedge clk) begin
    if (since == 0) slip = 0;
    if (int'(lat_tap) == glitch_tap && since == 8) slip = 1;
    bus.sample_d = link_mask[lat_tap] ? ((((since + phase_off + slip) % 2) == 1) ? ~PAT : PAT) : W'($urandom);
    if (rec && bus.delay_load) loads.push_back(bus.delay_tap);
    if (!rst && bus.delay_tap !== prev_tap && !bus.delay_load) tap_moves++;
    prev_tap = bus.delay_tap;
  end

  function automatic logic [NT-1:0] win(input int lo, input int hi);
    logic [NT-1:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Widest run of passing taps, first one wins ties
  function automatic void model(input logic [NT-1:0] m, output int bs, output int bl);
    int rs = 0, rl = 0;
    bs = 0;
    bl = 0;
    for (int t = 0; t <= NT; t++) begin
      if (t < NT && m[t]) begin
        if (rl == 0) rs = t;
        rl++;
      end else begin
        if (rl > bl) begin bl = rl; bs = rs; end
        rl = 0;
      end
    end
  endfunction

  task automatic run_sweep(input string name, input logic [NT-1:0] m, input int gt, input int off, input int kick);
    logic [NT-1:0] eff;
    int bs, bl, et, n, bad;
    eff = m;
    if (gt >= 0) eff[gt] = 1'b0;
    model(eff, bs, bl);
    et = bl >= 2 ? bs + (bl - 1) / 2 : 0;
    link_mask = m;
    glitch_tap = gt;
    phase_off = off;
    loads.delete();
    rec = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      bus.start = (n == kick);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    rec = 1'b0;
    compared++;
    if (n != 449) begin mismatched++; $display("FAIL %s busy_cycles: got %0d want 449", name, n); end
    compared++;
    if (bus.eye_start !== 5'(bs)) begin mismatched++; $display("FAIL %s eye_start: got %0d want %0d", name, bus.eye_start, bs); end
    compared++;
    if (bus.eye_width !== 6'(bl)) begin mismatched++; $display("FAIL %s eye_width: got %0d want %0d", name, bus.eye_width, bl); end
    compared++;
    if (bus.delay_tap !== 5'(et)) begin mismatched++; $display("FAIL %s delay_tap: got %0d want %0d", name, bus.delay_tap, et); end
    compared++;
    if (bus.locked !== (bl >= 2) || bus.error !== (bl < 2)) begin
      mismatched++; $display("FAIL %s lock_err: got %b/%b want %b/%b", name, bus.locked, bus.error, bl >= 2, bl < 2);
    end
    bad = loads.size() != 33 ? 1 : 0;
    if (bad == 0) begin
      for (int i = 0; i < 32; i++) if (loads[i] !== 5'(i)) bad++;
      if (loads[32] !== 5'(et)) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL %s load_seq: got %0d pulses / %0d wrong want 33 / 0", name, loads.size(), bad); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++;
    if ({bus.delay_tap, bus.delay_load, bus.busy, bus.locked, bus.error, bus.eye_start, bus.eye_width} !== 20'h0) begin
      mismatched++; $display("FAIL reset_outputs: got tap=%0d load=%b busy=%b", bus.delay_tap, bus.delay_load, bus.busy);
    end
    rst = 1'b0;
    loads.delete();
    rec = 1'b1;
    repeat (20) @(negedge clk);
    rec = 1'b0;
    compared++;
    if (loads.size() != 0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL idle_quiet: got loads=%0d busy=%b want 0 0", loads.size(), bus.busy);
    end
  endtask

  task automatic test_restart;
    compared++;
    if (bus.locked !== 1'b1) begin mismatched++; $display("FAIL restart_pre_locked: got %b want 1", bus.locked); end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    compared++;
    if ({bus.locked, bus.busy, bus.delay_load, bus.delay_tap} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin
      mismatched++; $display("FAIL restart_first_load: got locked=%b busy=%b load=%b tap=%0d want 0 1 1 0",
        bus.locked, bus.busy, bus.delay_load, bus.delay_tap);
    end
    for (int n = 0; n < 2000 && bus.busy === 1'b1; n++) @(negedge clk);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      logic [NT-1:0] m;
      int lo, hi, gt;
      if (k % 2 == 0) m = NT'($urandom);
      else begin
        lo = $urandom_range(0, NT - 1);
        hi = $urandom_range(lo, NT - 1);
        m = win(lo, hi) | win($urandom_range(0, 31), $urandom_range(0, 3) + 0) & win(0, 3);
      end
      gt = $urandom_range(0, 1) == 1 ? $urandom_range(0, NT - 1) : -1;
      run_sweep($sformatf("random%0d", k), m, gt, $urandom_range(0, 1), -1);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    link_mask = '1;
    glitch_tap = -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!(bus.delay_load === 1'b1 && bus.delay_tap === 5'd12) && n < 1000) begin n++; @(negedge clk); end
    compared++;
    if (n >= 1000) begin mismatched++; $display("FAIL reach_tap12: got timeout want load at tap 12"); end
    #1 rst = 1'b1;
    #1;
    compared++;
    if ({bus.delay_tap, bus.delay_load, bus.busy, bus.locked, bus.error, bus.eye_start, bus.eye_width} !== 20'h0) begin
      mismatched++; $display("FAIL reset_mid_outputs: got tap=%0d load=%b busy=%b want 0 0 0", bus.delay_tap, bus.delay_load, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    loads.delete();
    rec = 1'b1;
    repeat (40) @(negedge clk);
    rec = 1'b0;
    compared++;
    if (loads.size() != 0 || bus.busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_mid_quiet: got loads=%0d busy=%b want 0 0", loads.size(), bus.busy);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset;
    run_sweep("all_pass", '1, -1, 0, -1);
    run_sweep("window", win(10, 19), -1, 0, -1);
    test_restart;
    run_sweep("tie", win(3, 6) | win(20, 23), -1, 0, -1);
    run_sweep("last_tap", win(28, 31) | win(5, 7), -1, 1, -1);
    run_sweep("narrow", win(7, 7), -1, 0, -1);
    run_sweep("glitch", win(5, 12), 9, 0, -1);
    run_sweep("phase_inv", win(10, 19), -1, 1, -1);
    run_sweep("busy_start", win(2, 9), -1, 0, 100);
    test_random;
    test_reset_mid;
    compared++;
    if (tap_moves != 0) begin mismatched++; $display("FAIL tap_stable: got %0d moves without delay_load want 0", tap_moves); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ssio_delay_calib.md
Name: ssio_delay_calib

Overview:
- Calibration controller for a source-synchronous SDR input capture path with a programmable input delay line.
- On start, sweeps every delay tap and checks the captured data against an alternating training pattern at each tap.
- Finds the widest contiguous passing window and loads the tap at the centre of that window.
- Sits beside the SDR input register in the RX clock domain. Drives the delay line's tap/load interface and reports lock status to the MAC/PHY bring-up logic.

Parameters:
- WIDTH, 1, width of captured data bus.
- TAP_WIDTH, 5, delay tap code width; sweep covers taps 0 to 2^TAP_WIDTH-1.
- PATTERN, {WIDTH{1'b0}}, training word; the link alternates PATTERN / ~PATTERN every cycle.
- SETTLE_CYCLES, 16, wait cycles after each tap load before checking (>=1).
- CHECK_CYCLES, 64, consecutive samples checked per tap (>=2).
- MIN_EYE, 2, minimum passing-window width in taps required for lock (>=1).

Ports:
- clk  input  1  capture clock; all logic on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  pulse; begins calibration when not busy.
- sample_d  input  WIDTH  captured data from the SDR input register.
- delay_tap  output  TAP_WIDTH  tap code to the delay line.
- delay_load  output  1  one-cycle strobe; the delay line latches delay_tap.
- busy  output  1  calibration in progress.
- locked  output  1  last calibration succeeded.
- error  output  1  last calibration found no eye >= MIN_EYE.
- eye_start  output  TAP_WIDTH  first tap of the best window.
- eye_width  output  TAP_WIDTH+1  width of the best window in taps.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0.
- States: IDLE, LOAD, SETTLE, CHECK, EVAL, CENTER, DONE.
- IDLE/DONE:
  - start=1 -> LOAD with tap=0.
  - On entry to LOAD: busy=1; locked, error and run/best trackers cleared.
  - start while busy is ignored.
- LOAD (1 cycle): delay_load=1, delay_tap=current tap -> SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles -> CHECK.
- CHECK (exactly CHECK_CYCLES cycles), pass-flag rules:
  - First sample must equal PATTERN or ~PATTERN.
  - Each later sample must equal the bitwise inverse of the previous sample.
  - Any violation clears the pass flag for that tap.
- EVAL (1 cycle):
  - Pass: extend the current run; record the run start if the run length was 0.
  - Fail: close the current run.
  - Closing a run: replace best only if run length > best length (strict), so the first-found window wins ties.
  - At the last tap (all ones), a passing run is also closed.
  - Not last tap -> tap+1, LOAD. Last tap -> CENTER.
- Per-tap duration: SETTLE_CYCLES+CHECK_CYCLES+2 cycles.
- CENTER (1 cycle):
  - If best length >= MIN_EYE: delay_tap = best_start + ((best_len-1)>>1) (floor toward the lower tap), locked=1.
  - Otherwise: delay_tap=0, error=1.
  - delay_load=1 in both cases; eye_start/eye_width updated from best -> DONE.
- DONE: busy=0. delay_tap, locked, error, eye_start and eye_width hold until the next start or reset.
- Arithmetic widths:
  - Run/best length counters are TAP_WIDTH+1 bits (a full sweep of 2^TAP_WIDTH taps must not overflow).
  - Centre sum is computed at TAP_WIDTH+1 bits; the result always fits in TAP_WIDTH.
- delay_load is never asserted outside LOAD and CENTER.
- delay_tap changes only in the cycle delay_load is asserted.
- Reset mid-sweep aborts immediately to reset values; no further delay_load until a new start.

Test Plan (TAP_WIDTH=5, SETTLE=4, CHECK=8, MIN_EYE=2 unless noted; bench models the link as clean alternating data in the pass taps and random data elsewhere):
- All 32 taps pass -> eye_start=0, eye_width=32, final delay_tap=15, locked=1, error=0. busy falls 32*14+1 cycles after the cycle following start.
- Taps 10..19 pass -> eye_start=10, eye_width=10, final tap=14, locked=1. Exactly 33 delay_load pulses, at taps 0..31 then 14.
- Windows 3..6 and 20..23 -> tie resolved to the first: eye_start=3, eye_width=4, tap=4. A window of 28..31 also closes at the last tap: widen it to 28..31 plus 0..1 failing and check eye_start=28 when it is the largest.
- Only tap 7 passes (MIN_EYE=2) -> error=1, locked=0, final delay_tap=0, eye_width=1.
- Tap 9 passes except one non-inverted sample mid-CHECK -> tap 9 treated as failing.
- Phase: the pattern starting on ~PATTERN passes.
- start pulsed during busy -> no restart; sweep timing unchanged.
- rst asserted at tap 12 -> all outputs 0 immediately.
- New start after a successful run clears locked on the first LOAD cycle.
